// File: rtl/time_set_ctrl.sv
// Time-set control for the HH:MM:SS timer: button debounce, RUN/SET_H/SET_M/SET_S editor, load strobe, blink; `AUTO_REPEAT_EN adds held-inc auto-repeat.
// Latency: raw press -> event 2+DEBOUNCE_LIMIT cycles, event -> outputs 1 cycle; no backpressure, the timer must accept load when strobed.
module time_set_ctrl #(
  parameter int DEBOUNCE_W     = 20,
  parameter int DEBOUNCE_LIMIT = 500000,
  parameter int BLINK_W        = 25,
  parameter int BLINK_LIMIT    = 12500000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int HOLD_LIMIT     = 25000000,
  parameter int REPEAT_LIMIT   = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load,
  output logic       timer_enabled,
  output logic [1:0] edit_field,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [DEBOUNCE_W-1:0] DB_MAX = DEBOUNCE_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [BLINK_W-1:0]    BL_MAX = BLINK_W'(BLINK_LIMIT - 1);

  // bit 0 = mode button, bit 1 = inc button
  logic [1:0]                 raw;
  logic [1:0]                 sync0;
  logic [1:0]                 sync1;
  logic [1:0]                 stable;
  logic [1:0]                 ev;
  logic [1:0][DEBOUNCE_W-1:0] db_cnt;

  assign raw = {btn_inc, btn_mode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0  <= 2'b11;
      sync1  <= 2'b11;
      stable <= 2'b00;
      ev     <= 2'b00;
      db_cnt <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      ev    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (~sync1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i] <= '0;
          stable[i] <= ~sync1[i];
          ev[i]     <= ~sync1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic   mode_ev;
  logic   inc_ev;
  logic   inc_step;
  state_t state;

  assign mode_ev = ev[0];
  assign inc_ev  = ev[1];

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);
  localparam int RPT_W  = $clog2(REPEAT_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT - 1);
  localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'(REPEAT_LIMIT - 1);

  logic              rpt_armed;
  logic              rpt_active;
  logic              rpt_tick;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RPT_W-1:0]  rpt_cnt;

  // Arms on an accepted inc event; any mode event, release, or RUN state drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_armed  <= 1'b0;
      rpt_active <= 1'b0;
      rpt_tick   <= 1'b0;
      hold_cnt   <= '0;
      rpt_cnt    <= '0;
    end else begin
      rpt_tick <= 1'b0;
      if (mode_ev || !stable[1] || state == RUN) begin
        rpt_armed  <= 1'b0;
        rpt_active <= 1'b0;
        hold_cnt   <= '0;
        rpt_cnt    <= '0;
      end else if (inc_ev) begin
        rpt_armed  <= 1'b1;
        rpt_active <= 1'b0;
        hold_cnt   <= '0;
      end else if (rpt_armed && !rpt_active) begin
        if (hold_cnt == HOLD_MAX) begin
          rpt_active <= 1'b1;
          rpt_cnt    <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else if (rpt_active) begin
        if (rpt_cnt == RPT_MAX) begin
          rpt_tick <= 1'b1;
          rpt_cnt  <= '0;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign inc_step = inc_ev | rpt_tick;
`else
  assign inc_step = inc_ev;
`endif

  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      set_hours     <= 6'd0;
      set_minutes   <= 6'd0;
      set_seconds   <= 6'd0;
      load          <= 1'b0;
      timer_enabled <= 1'b1;
      edit_field    <= 2'd0;
      blink         <= 1'b0;
      blink_cnt     <= '0;
    end else begin
      load <= 1'b0;
      if (state == RUN) begin
        blink         <= 1'b0;
        blink_cnt     <= '0;
        timer_enabled <= 1'b1;
        if (mode_ev) begin
          state         <= SET_H;
          edit_field    <= 2'd1;
          timer_enabled <= 1'b0;
          set_hours     <= (cur_hours   < 6'd24) ? cur_hours   : 6'd0;
          set_minutes   <= (cur_minutes < 6'd60) ? cur_minutes : 6'd0;
          set_seconds   <= (cur_seconds < 6'd60) ? cur_seconds : 6'd0;
        end
      end else if (mode_ev) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
        case (state)
          SET_H: begin
            state      <= SET_M;
            edit_field <= 2'd2;
          end
          SET_M: begin
            state      <= SET_S;
            edit_field <= 2'd3;
          end
          default: begin
            // timer_enabled stays low during the load cycle; RUN raises it next cycle
            state      <= RUN;
            edit_field <= 2'd0;
            load       <= 1'b1;
          end
        endcase
      end else if (inc_step) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
        case (state)
          SET_H:   set_hours   <= (set_hours   == 6'd23) ? 6'd0 : set_hours   + 6'd1;
          SET_M:   set_minutes <= (set_minutes == 6'd59) ? 6'd0 : set_minutes + 6'd1;
          default: set_seconds <= (set_seconds == 6'd59) ? 6'd0 : set_seconds + 6'd1;
        endcase
      end else if (blink_cnt == BL_MAX) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule
